// File: rtl/matrix_vector_product.sv
// Tiled transposed matrix-vector product: result[c] = sum_r matrix[r][c] * vector[r].
// Optional clamping of result cells is enabled with the SATURATE_EN macro (default build wraps).
module matrix_vector_product #(
  parameter int MATRIX_ROWS       = 5,
  parameter int MATRIX_COLS       = 5,
  parameter int MATRIX_CELL_WIDTH = 8,
  parameter int VECTOR_CELL_WIDTH = 8,
  parameter int RESULT_CELL_WIDTH = 12,
  parameter int FRACTION_WIDTH    = 1,
  parameter int TILING_ROW        = 2,
  parameter int TILING_COL        = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic [MATRIX_ROWS*MATRIX_COLS*MATRIX_CELL_WIDTH-1:0]   matrix,
  input  logic [MATRIX_ROWS*VECTOR_CELL_WIDTH-1:0]               vector,
  output logic [MATRIX_COLS*RESULT_CELL_WIDTH-1:0]               result,
  output logic                                                   valid,
  output logic                                                   error
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // CALC   | one tile per cycle; last_q marks the extra conversion cycle
  // DONE   | result/valid/error held until start or rst
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int ROWS = MATRIX_ROWS;
  localparam int COLS = MATRIX_COLS;
  localparam int MW   = MATRIX_CELL_WIDTH;
  localparam int VW   = VECTOR_CELL_WIDTH;
  localparam int RW   = RESULT_CELL_WIDTH;
  localparam int TR   = TILING_ROW;
  localparam int TC   = TILING_COL;
  localparam int PW   = MW + VW;
  localparam int AW   = PW + $clog2(ROWS);
  localparam int NRT  = (ROWS + TR - 1) / TR;
  localparam int NCT  = (COLS + TC - 1) / TC;
  localparam int RTW  = (NRT > 1) ? $clog2(NRT) : 1;
  localparam int CTW  = (NCT > 1) ? $clog2(NCT) : 1;

  logic [1:0]              state_q;
  logic [RTW-1:0]          rt_q;
  logic [CTW-1:0]          ct_q;
  logic                    last_q;
  logic signed [MW-1:0]    mat_q  [ROWS][COLS];
  logic signed [VW-1:0]    vec_q  [ROWS];
  logic signed [AW-1:0]    acc_q  [COLS];
  logic signed [AW-1:0]    acc_next [COLS];
  logic signed [MW-1:0]    m_sel  [TR][TC];
  logic signed [VW-1:0]    v_sel  [TR];
  logic signed [PW-1:0]    prod_full [TR][TC];
  logic signed [PW-1:0]    prod_sh   [TR][TC];
  logic [RW-1:0]           res_next [COLS];

  // Operand muxes select the current tile; cells past the matrix edge never match and stay zero.
  always_comb begin
    for (int i = 0; i < TR; i++) begin
      v_sel[i] = '0;
      for (int r = 0; r < ROWS; r++)
        if ((r % TR) == i && rt_q == RTW'(r / TR)) v_sel[i] = vec_q[r];
      for (int j = 0; j < TC; j++) begin
        m_sel[i][j] = '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if ((r % TR) == i && (c % TC) == j && rt_q == RTW'(r / TR) && ct_q == CTW'(c / TC))
              m_sel[i][j] = mat_q[r][c];
        prod_full[i][j] = PW'(m_sel[i][j]) * PW'(v_sel[i]);
        prod_sh[i][j]   = prod_full[i][j] >>> FRACTION_WIDTH;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      acc_next[c] = acc_q[c];
      for (int i = 0; i < TR; i++)
        for (int j = 0; j < TC; j++)
          if ((c % TC) == j && ct_q == CTW'(c / TC))
            acc_next[c] = acc_next[c] + AW'(prod_sh[i][j]);
    end
  end

`ifdef SATURATE_EN
  localparam logic signed [RW-1:0] RES_MAX = {1'b0, {(RW-1){1'b1}}};
  localparam logic signed [RW-1:0] RES_MIN = {1'b1, {(RW-1){1'b0}}};
  logic sat_any;

  always_comb begin
    sat_any = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      res_next[c] = acc_q[c][RW-1:0];
      if (acc_q[c] > AW'(RES_MAX)) begin
        res_next[c] = RES_MAX;
        sat_any     = 1'b1;
      end else if (acc_q[c] < AW'(RES_MIN)) begin
        res_next[c] = RES_MIN;
        sat_any     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    for (int c = 0; c < COLS; c++) res_next[c] = acc_q[c][RW-1:0];
  end

  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rt_q    <= '0;
      ct_q    <= '0;
      last_q  <= 1'b0;
      valid   <= 1'b0;
      result  <= '0;
`ifdef SATURATE_EN
      error   <= 1'b0;
`endif
      for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int r = 0; r < ROWS; r++) begin
              vec_q[r] <= vector[r*VW +: VW];
              for (int c = 0; c < COLS; c++)
                mat_q[r][c] <= matrix[(r*COLS+c)*MW +: MW];
            end
            for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
            rt_q    <= '0;
            ct_q    <= '0;
            last_q  <= 1'b0;
            valid   <= 1'b0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (last_q) begin
            for (int c = 0; c < COLS; c++) result[c*RW +: RW] <= res_next[c];
`ifdef SATURATE_EN
            error   <= sat_any;
`endif
            valid   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            for (int c = 0; c < COLS; c++) acc_q[c] <= acc_next[c];
            if (rt_q == RTW'(NRT - 1)) begin
              rt_q <= '0;
              if (ct_q == CTW'(NCT - 1)) last_q <= 1'b1;
              else                       ct_q   <= ct_q + CTW'(1);
            end else begin
              rt_q <= rt_q + RTW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_vector_product.sv
// Self-checking bench for matrix_vector_product: a plain-arithmetic reference model with
// per-cycle comparison of two instances (2x2 and 3x4 tiling), plus literal spot checks.
module tb_matrix_vector_product;
  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int MW   = 8;
  localparam int VW   = 8;
  localparam int RW   = 12;
  localparam int N1   = 9;
  localparam int N2   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [ROWS*COLS*MW-1:0] matrix = '0;
  logic [ROWS*VW-1:0]      vector = '0;
  logic [COLS*RW-1:0]      result, result2;
  logic                    valid, valid2, error, error2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_vector_product dut (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix), .vector(vector),
    .result(result), .valid(valid), .error(error));

  matrix_vector_product #(.TILING_ROW(3), .TILING_COL(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .matrix(matrix), .vector(vector),
    .result(result2), .valid(valid2), .error(error2));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer sums with floor shift, then clamp or wrap.
  task automatic model_calc(input logic [ROWS*COLS*MW-1:0] m, input logic [ROWS*VW-1:0] v,
                            output logic [COLS*RW-1:0] res, output logic err);
    int a, p;
    logic [31:0] au;
    res = '0;
    err = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      a = 0;
      for (int r = 0; r < ROWS; r++) begin
        p = int'($signed(m[(r*COLS+c)*MW +: MW])) * int'($signed(v[r*VW +: VW]));
        a += p >>> 1;
      end
`ifdef SATURATE_EN
      if (a > 2047) begin a = 2047; err = 1'b1; end
      else if (a < -2048) begin a = -2048; err = 1'b1; end
`endif
      au = a;
      res[c*RW +: RW] = au[RW-1:0];
    end
  endtask

  function automatic logic [COLS*RW-1:0] pack_res(input int a0, a1, a2, a3, a4);
    int vals[5];
    logic [31:0] t;
    logic [COLS*RW-1:0] r;
    vals = '{a0, a1, a2, a3, a4};
    r = '0;
    for (int c = 0; c < COLS; c++) begin
      t = vals[c];
      r[c*RW +: RW] = t[RW-1:0];
    end
    return r;
  endfunction

  function automatic logic [ROWS*VW-1:0] pack_vec(input int a0, a1, a2, a3, a4);
    int vals[5];
    logic [31:0] t;
    logic [ROWS*VW-1:0] r;
    vals = '{a0, a1, a2, a3, a4};
    r = '0;
    for (int i = 0; i < ROWS; i++) begin
      t = vals[i];
      r[i*VW +: VW] = t[VW-1:0];
    end
    return r;
  endfunction

  function automatic logic [ROWS*COLS*MW-1:0] mat_fill(input int diag_val, input int off_val);
    logic [31:0] t;
    logic [ROWS*COLS*MW-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        t = (r == c) ? diag_val : off_val;
        m[(r*COLS+c)*MW +: MW] = t[MW-1:0];
      end
    return m;
  endfunction

  function automatic logic [ROWS*COLS*MW-1:0] rand_mat();
    logic [ROWS*COLS*MW-1:0] m;
    for (int b = 0; b < ROWS*COLS*MW; b++) m[b] = 1'($urandom_range(0, 1));
    return m;
  endfunction

  function automatic logic [ROWS*VW-1:0] rand_vec();
    logic [ROWS*VW-1:0] v;
    for (int b = 0; b < ROWS*VW; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Transaction-level timing model: a launch schedules the product N+1 edges later.
  int                 cnt       [2];
  logic               exp_valid [2];
  logic               exp_err   [2];
  logic [COLS*RW-1:0] exp_res   [2];
  logic [COLS*RW-1:0] pend_res  [2];
  logic               pend_err  [2];
  logic               model_live = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic s;
      s = (k == 0) ? start : start2;
      if (rst) begin
        cnt[k] = 0;
        exp_valid[k] = 1'b0;
        exp_err[k] = 1'b0;
        exp_res[k] = '0;
      end else if (cnt[k] > 0) begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) begin
          exp_valid[k] = 1'b1;
          exp_res[k]   = pend_res[k];
          exp_err[k]   = pend_err[k];
        end
      end else if (s) begin
        model_calc(matrix, vector, pend_res[k], pend_err[k]);
        cnt[k] = ((k == 0) ? N1 : N2) + 1;
        exp_valid[k] = 1'b0;
      end
    end
    if (rst) model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("valid", 64'(valid), 64'(exp_valid[0]));
      check("result", 64'(result), 64'(exp_res[0]));
      check("error", 64'(error), 64'(exp_err[0]));
      check("valid2", 64'(valid2), 64'(exp_valid[1]));
      check("result2", 64'(result2), 64'(exp_res[1]));
      check("error2", 64'(error2), 64'(exp_err[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Launch on one instance and pin the exact cycle valid rises; inputs are scrambled
  // mid-run to show only the launch-cycle values matter.
  task automatic launch_and_time(input int k, input int n, input bit pulse, input string tag);
    logic [ROWS*COLS*MW-1:0] m_keep;
    logic [ROWS*VW-1:0] v_keep;
    m_keep = matrix;
    v_keep = vector;
    if (k == 0) start = 1'b1; else start2 = 1'b1;
    tick();
    start = 1'b0;
    start2 = 1'b0;
    check({tag, "_drop"}, 64'((k == 0) ? valid : valid2), 64'(0));
    for (int i = 1; i <= n; i++) begin
      if (i == 2) begin
        matrix = rand_mat();
        vector = rand_vec();
      end
      if (pulse && i == 3) begin
        if (k == 0) start = 1'b1; else start2 = 1'b1;
      end else begin
        start = 1'b0;
        start2 = 1'b0;
      end
      tick();
      check({tag, "_early"}, 64'((k == 0) ? valid : valid2), 64'(0));
    end
    start = 1'b0;
    start2 = 1'b0;
    tick();
    check({tag, "_valid"}, 64'((k == 0) ? valid : valid2), 64'(1));
    matrix = m_keep;
    vector = v_keep;
  endtask

  logic [ROWS*VW-1:0] tv;
  logic [COLS*RW-1:0] diag_exp, ninety, mres;
  logic merr;

  initial begin
    tv       = pack_vec(10, 20, -30, 40, 50);
    diag_exp = pack_res(10, 20, -30, 40, 50);
    ninety   = pack_res(90, 90, 90, 90, 90);

    model_calc(mat_fill(2, 2), tv, mres, merr);
    check("model_all2", 64'(mres), 64'(ninety));
    model_calc(mat_fill(2, 0), tv, mres, merr);
    check("model_diag", 64'(mres), 64'(diag_exp));

    rst = 1'b1;
    repeat (2) tick();
    check("rst_result", 64'(result), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    rst = 1'b0;
    tick();

    matrix = mat_fill(2, 0);
    vector = tv;
    launch_and_time(0, N1, 1'b0, "diag");
    check("diag_res", 64'(result), 64'(diag_exp));
    check("diag_err", 64'(error), 64'(0));

    matrix = mat_fill(2, 2);
    launch_and_time(0, N1, 1'b0, "all2");
    check("all2_res", 64'(result), 64'(ninety));
    check("all2_err", 64'(error), 64'(0));

    matrix = mat_fill(127, 127);
    vector = pack_vec(127, 127, 127, 127, 127);
    launch_and_time(0, N1, 1'b0, "satp");
`ifdef SATURATE_EN
    check("satp_res", 64'(result), 64'(pack_res(2047, 2047, 2047, 2047, 2047)));
    check("satp_err", 64'(error), 64'(1));
`else
    check("satp_res", 64'(result), 64'(pack_res(-640, -640, -640, -640, -640)));
    check("satp_err", 64'(error), 64'(0));
`endif
    vector = pack_vec(-128, -128, -128, -128, -128);
    launch_and_time(0, N1, 1'b0, "satn");
`ifdef SATURATE_EN
    check("satn_res", 64'(result), 64'(pack_res(-2048, -2048, -2048, -2048, -2048)));
    check("satn_err", 64'(error), 64'(1));
`else
    check("satn_res", 64'(result), 64'(pack_res(320, 320, 320, 320, 320)));
    check("satn_err", 64'(error), 64'(0));
`endif

    matrix = mat_fill(2, 0);
    vector = tv;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_valid", 64'(valid), 64'(0));
    check("midrst_error", 64'(error), 64'(0));
    launch_and_time(0, N1, 1'b0, "afterrst");
    check("afterrst_res", 64'(result), 64'(diag_exp));

    matrix = mat_fill(2, 2);
    launch_and_time(0, N1, 1'b1, "pulse");
    check("pulse_res", 64'(result), 64'(ninety));

    launch_and_time(1, N2, 1'b0, "tile34");
    check("tile34_res", 64'(result2), 64'(ninety));
    check("tile34_err", 64'(error2), 64'(0));

    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) matrix = rand_mat();
      if ($urandom_range(0, 3) == 0) vector = rand_vec();
      start  = ($urandom_range(0, 6) == 0);
      start2 = ($urandom_range(0, 6) == 0);
      rst    = ($urandom_range(0, 80) == 0);
      tick();
    end
    start = 1'b0;
    start2 = 1'b0;
    rst = 1'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_vector_product.md
# matrix_vector_product

Tiled fixed-point transposed matrix-vector product, result[c] = Σ_r matrix[r][c]·vector[r], used on the backward pass to push an error vector back through a weight matrix laid out in the flattened outer-product format. It is the contraction counterpart of `tensor_product`: it consumes a ROWS×COLS matrix in the same flattened layout, multiplies by a ROWS-long vector, and emits a COLS-long vector. It processes TILING_ROW×TILING_COL cells per cycle under a start/valid/error handshake.

## Interface
- MATRIX_ROWS, 5, number of matrix rows = input vector length
- MATRIX_COLS, 5, number of matrix columns = result vector length
- MATRIX_CELL_WIDTH, 8, signed matrix cell width
- VECTOR_CELL_WIDTH, 8, signed input vector cell width
- RESULT_CELL_WIDTH, 12, signed result cell width
- FRACTION_WIDTH, 1, fraction bits shared by matrix and vector
- TILING_ROW, 2, rows processed per cycle
- TILING_COL, 2, columns processed per cycle
- clk  input  1  clock; everything on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request, sampled only in IDLE or DONE
- matrix  input  MATRIX_ROWS*MATRIX_COLS*MATRIX_CELL_WIDTH  cell (r,c) at bits [(r*MATRIX_COLS+c)*MATRIX_CELL_WIDTH +: MATRIX_CELL_WIDTH]
- vector  input  MATRIX_ROWS*VECTOR_CELL_WIDTH  cell r at [r*VECTOR_CELL_WIDTH +: VECTOR_CELL_WIDTH]
- result  output  MATRIX_COLS*RESULT_CELL_WIDTH  cell c at [c*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH], registered
- valid  output  1  result holds the completed product
- error  output  1  at least one result cell overflowed in the last run

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE/DONE + start: latch matrix and vector into internal registers; clear accumulators, row-tile and column-tile counters; clear valid; → CALC.
- CALC: each cycle processes one tile, rows [rt*TILING_ROW, +TILING_ROW), cols [ct*TILING_COL, +TILING_COL). Row tile is the inner counter, column tile the outer. Cells beyond MATRIX_ROWS/MATRIX_COLS in partial tiles contribute zero.
- Per cell: full signed product (MATRIX_CELL_WIDTH+VECTOR_CELL_WIDTH bits), arithmetic shift right by FRACTION_WIDTH (floor), added to accumulator acc[c]. Accumulator width MATRIX_CELL_WIDTH+VECTOR_CELL_WIDTH+clog2(MATRIX_ROWS); it never overflows.
- After the last tile: convert each acc[c] to RESULT_CELL_WIDTH (see Configuration), register into result, set valid and error, → DONE.
- DONE: result, valid, error held until start or rst.
- start in CALC is ignored; inputs changing after the launch cycle have no effect.

## Timing
- Reset values: result=0, valid=0, error=0, state IDLE, accumulators 0.
- N = ceil(MATRIX_ROWS/TILING_ROW) × ceil(MATRIX_COLS/TILING_COL) tiles.
- start sampled at edge 0 → tiles on edges 1..N → valid=1 and result updated after edge N+1 (latency N+1 cycles).
- Relaunch from DONE: valid falls after the launch edge; result keeps the old value until the new completion.
- rst in any state, including mid-CALC: next edge forces reset values; the partial run is discarded. rst wins over simultaneous start.

## Configuration
- SATURATE_EN defined: result cell clamps to [-2^(RESULT_CELL_WIDTH-1), 2^(RESULT_CELL_WIDTH-1)-1]; error=1 if any cell clamped.
- SATURATE_EN undefined: result cell = low RESULT_CELL_WIDTH bits of acc (wrap); error is tied 0.

## Test plan
Defaults (5×5, 8/8/12, FRACTION_WIDTH=1, tiling 2×2, N=9), vector={r0..r4}={10,20,-30,40,50}.
- Diagonal matrix raw 2 (1.0), else 0; start at cycle 0 → valid after edge 10, result={10,20,-30,40,50}, error=0.
- All-cells raw 2 → every result cell = 90, error=0; valid low during cycles 1..9.
- SATURATE_EN, matrix all 127, vector all 127 → every cell 2047, error=1; vector all -128 → every cell -2048, error=1; without macro, 40320 wraps to -640.
- rst asserted at cycle 4 of a run → result=0, valid=0, error=0 next cycle; fresh start then yields the correct diagonal result after 10 cycles.
- start pulsed at cycle 3 of CALC → ignored, valid still after edge 10; start in DONE → valid drops next cycle, new result after N+1.
- TILING_ROW=3, TILING_COL=4 (N=4) with the all-ones-raw-2 matrix → valid after edge 5, every cell 90.
